// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : 4-digit seven-segment scan controller with per-slot blanking,
//            digit skipping and a frame pulse. Optional macro SCAN_DIMMING_EN
//            adds a brightness input with 4-bit PWM dimming.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIV_WIDTH        = 16,
    parameter int CLK_DIV          = 50000,
    parameter int BLANK_CYCLES     = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit_en,
`ifdef SCAN_DIMMING_EN
    input  logic [3:0] brightness,
`endif
    output logic [1:0] sel,
    output logic [3:0] anode,
    output logic       blank,
    output logic       frame_tick
);

    localparam logic [1:0] c_st_off   = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;

    localparam logic [3:0]           c_anode_off  = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [DIV_WIDTH-1:0] c_cnt_last   = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] c_blank_last = DIV_WIDTH'(BLANK_CYCLES - 1);

    logic [1:0]           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [1:0]           r_sel;
    logic [3:0]           r_anode;
    logic                 r_blank;
    logic                 r_tick;

    logic [1:0]           w_state_nxt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [1:0]           w_sel_nxt;
    logic                 w_wrap;
    logic                 w_run;
    logic                 w_show_on;
    logic                 w_dim_on;
    logic [3:0]           w_anode_nxt;

    function automatic logic [1:0] f_first(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Nearest enabled index above s (wrapping); s itself if no other is enabled.
    function automatic logic [1:0] f_next(input logic [3:0] m, input logic [1:0] s);
        logic [1:0] v_k;
        logic [1:0] v_res;
        v_res = s;
        for (int i = 3; i >= 1; i--) begin
            v_k = s + 2'(i);
            if (m[v_k]) v_res = v_k;
        end
        return v_res;
    endfunction

    assign w_run = en && (digit_en != 4'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_off;
            r_cnt   <= '0;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_wrap      = 1'b0;
        if (!w_run) begin
            w_state_nxt = c_st_off;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_st_off: begin
                    w_state_nxt = c_st_blank;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = f_first(digit_en);
                end
                c_st_blank: begin
                    w_cnt_nxt = r_cnt + DIV_WIDTH'(1);
                    if (r_cnt == c_blank_last) w_state_nxt = c_st_show;
                end
                c_st_show: begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = c_st_blank;
                        w_cnt_nxt   = '0;
                        w_sel_nxt   = f_next(digit_en, r_sel);
                        w_wrap      = (f_next(digit_en, r_sel) <= r_sel);
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_st_off;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef SCAN_DIMMING_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_nxt;

    assign w_pwm_nxt = r_pwm + 4'd1;
    // Anode is registered, so gate against the pwm value of the cycle it appears in.
    assign w_dim_on  = (brightness == 4'hF) || (w_pwm_nxt < brightness);

    always_ff @(posedge clk) begin
        if (reset) r_pwm <= 4'd0;
        else       r_pwm <= w_pwm_nxt;
    end
`else
    assign w_dim_on = 1'b1;
`endif

    always_comb begin
        w_show_on   = (w_state_nxt == c_st_show) && digit_en[w_sel_nxt] && w_dim_on;
        w_anode_nxt = c_anode_off;
        if (w_show_on) w_anode_nxt = c_anode_off ^ (4'b0001 << w_sel_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode <= c_anode_off;
            r_blank <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_anode <= w_anode_nxt;
            r_blank <= !w_show_on;
            r_tick  <= w_wrap;
        end
    end

    assign sel        = r_sel;
    assign anode      = r_anode;
    assign blank      = r_blank;
    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Scoreboard bench for seg_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int TB_BLANK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] digit_en = 4'h0;
    logic [1:0] sel;
    logic [3:0] anode;
    logic       blank;
    logic       frame_tick;
`ifdef SCAN_DIMMING_EN
    logic [3:0] brightness = 4'hF;
`endif

    typedef struct {
        logic [1:0] sel;
        logic [3:0] anode;
        logic       blank;
        logic       ft;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pwm_exp = 0;

    seg_scan_ctrl #(
        .DIV_WIDTH(16),
        .CLK_DIV(8),
        .BLANK_CYCLES(TB_BLANK),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .digit_en(digit_en),
`ifdef SCAN_DIMMING_EN
        .brightness(brightness),
`endif
        .sel(sel),
        .anode(anode),
        .blank(blank),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Monitor: one expected entry per clock, sampled 2 time units after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (sel !== e.sel || anode !== e.anode || blank !== e.blank || frame_tick !== e.ft) begin
                    errors++;
                    $display("FAIL %s @%0t: got sel=%0d anode=%b blank=%b tick=%b, want sel=%0d anode=%b blank=%b tick=%b",
                             e.tag, $time, sel, anode, blank, frame_tick, e.sel, e.anode, e.blank, e.ft);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic rs, input logic e, input logic [3:0] de, input logic [1:0] s,
                       input logic show, input logic ft, input string tag);
        exp_t x;
        logic on;
        @(negedge clk);
        reset    = rs;
        en       = e;
        digit_en = de;
        pwm_exp  = rs ? 0 : (pwm_exp + 1) % 16;
        on = show;
`ifdef SCAN_DIMMING_EN
        if (brightness != 4'hF && pwm_exp >= int'(brightness)) on = 1'b0;
`endif
        x.sel   = s;
        x.anode = on ? ~(4'b0001 << s) : 4'hF;
        x.blank = !on;
        x.ft    = ft;
        x.tag   = tag;
        q.push_back(x);
    endtask

    task automatic slot(input logic [3:0] de, input logic [1:0] s, input int c0, input int c1,
                        input logic tk, input string tag);
        for (int c = c0; c <= c1; c++)
            cyc(1'b0, 1'b1, de, s, c >= TB_BLANK, tk && (c == 0), tag);
    endtask

    task automatic off(input int n, input logic [1:0] s, input string tag);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 1'b0, 4'hF, s, 1'b0, 1'b0, tag);
    endtask

    initial begin
        // Reset, then idle with en low
        cyc(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, "reset");
        cyc(1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, "reset");
        off(3, 2'd0, "idle_en0");

        // All four digits: 0,1,2,3,0 with a tick on the 3->0 edge
        for (int i = 0; i < 5; i++) slot(4'hF, 2'(i % 4), 0, 7, i == 4, "scan_all");
        off(2, 2'd0, "off_a");

        // Digits 0 and 2 only
        for (int i = 0; i < 5; i++)
            slot(4'b0101, (i % 2 == 1) ? 2'd2 : 2'd0, 0, 7, (i == 2) || (i == 4), "scan_0101");
        off(2, 2'd0, "off_b");

        // Drop en during SHOW with sel=1, then re-enable with digits 2,3
        slot(4'hF, 2'd0, 0, 7, 1'b0, "pre_drop");
        slot(4'hF, 2'd1, 0, 4, 1'b0, "pre_drop");
        off(2, 2'd1, "en_drop");
        slot(4'b1100, 2'd2, 0, 7, 1'b0, "reenable");
        slot(4'b1100, 2'd3, 0, 7, 1'b0, "reenable");
        slot(4'b1100, 2'd2, 0, 7, 1'b1, "reenable");

        // Reset mid-slot with sel=3, then a single enabled digit
        slot(4'b1100, 2'd3, 0, 3, 1'b0, "pre_rst");
        cyc(1'b1, 1'b1, 4'b0010, 2'd0, 1'b0, 1'b0, "mid_rst");
        for (int i = 0; i < 3; i++) slot(4'b0010, 2'd1, 0, 7, i > 0, "single");
        off(2, 2'd1, "off_c");

        // digit_en[sel] cleared mid-SHOW: dark for the rest of the slot, then advance
        slot(4'hF, 2'd0, 0, 7, 1'b0, "clr");
        slot(4'hF, 2'd1, 0, 4, 1'b0, "clr");
        for (int c = 5; c <= 7; c++) cyc(1'b0, 1'b1, 4'b1101, 2'd1, 1'b0, 1'b0, "clr_dark");
        slot(4'b1101, 2'd2, 0, 7, 1'b0, "clr_next");
        slot(4'b1101, 2'd3, 0, 7, 1'b0, "clr_next");
        slot(4'b1101, 2'd0, 0, 7, 1'b1, "clr_next");
        off(2, 2'd0, "off_d");

`ifdef SCAN_DIMMING_EN
        brightness = 4'd4;
        for (int i = 0; i < 4; i++) slot(4'hF, 2'(i), 0, 7, 1'b0, "dim4");
        brightness = 4'd0;
        for (int i = 0; i < 4; i++) slot(4'hF, 2'(i), 0, 7, i == 0, "dim0");
        brightness = 4'hF;
        off(2, 2'd3, "off_e");
`endif

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
